up_interface_initiator: RTL and testbench

- Microprocessor-side initiator for the 32-bit byte-serial handshake interface; drives transactions into the FPGA-side interface FSM.
- Used as the on-chip initiator for loopback/self-test and as the synthesizable model of the uP end.
- Each transaction writes N command words to the target, waits for bus turnaround, then reads M reply words.
- Words move as 4 bytes, little-endian (bits 7:0 first), each byte under a four-phase handshake.

---
 rtl/up_if_pkg.sv | 21 ++
 rtl/up_if_sync.sv | 26 ++
 rtl/up_interface_initiator.sv | 209 ++++++++++++++++++++
 tb/tb_up_interface_initiator.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_if_pkg.sv
// Shared types and constants for the uP-side byte-serial handshake initiator.
package up_if_pkg;

    localparam int BYTES_PER_WORD         = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [3:0] {
        IDLE,
        W_LOAD,
        W_SETUP,
        W_REQ,
        W_REL,
        TURN,
        R_WAIT,
        R_ACK,
        R_DELIVER,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/up_if_sync.sv
// Flop-chain synchronizer for one asynchronous handshake input; clears to 0 on reset.
module up_if_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/up_interface_initiator.sv
// uP-side initiator: writes N command words, turns the bus around, reads M reply words,
// each word moved as four little-endian bytes under a four-phase handshake.
module up_interface_initiator
    import up_if_pkg::*;
#(
    parameter int  MAX_WORDS      = 16,
    parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int  SYNC_STAGES    = 2,
    localparam int CNT_W          = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_cmd_words,
    input  logic [CNT_W-1:0] n_reply_words,
    input  logic [31:0]      cmd_word,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [31:0]      reply_word,
    output logic             reply_valid,
    input  logic             reply_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       bus_data_out,
    output logic             bus_data_oe,
    input  logic [7:0]       bus_data_in,
    input  logic             RW,
    output logic             handshake1_2,
    input  logic             handshake1_1,
    input  logic             handshake2_2,
    output logic             handshake2_1,
    output logic [3:0]       state_dbg
);

    localparam int         IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int         TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES_PER_WORD - 1);
    localparam [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_WORDS);
    localparam [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    logic ack_s, rdy_s, rw_s;

    up_if_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (.clk(clk), .reset(reset), .d(handshake1_1), .q(ack_s));
    up_if_sync #(.STAGES(SYNC_STAGES)) u_sync_rdy (.clk(clk), .reset(reset), .d(handshake2_2), .q(rdy_s));
    up_if_sync #(.STAGES(SYNC_STAGES)) u_sync_rw  (.clk(clk), .reset(reset), .d(RW),           .q(rw_s));

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   n_cmd_q, n_cmd_n, n_reply_q, n_reply_n;
    logic [CNT_W-1:0]   wcnt_q, wcnt_n, rcnt_q, rcnt_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [31:0]        shift_q, shift_n, reply_q, reply_n;
    logic [TMO_W-1:0]   tmo_q;
    logic               counting, tmo_hit, write_phase_n;

    // cmd and reply are valid/ready channels: a word moves on a clock edge where
    // valid and ready are both 1; valid holds its word stable until that edge.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        return (n > MAX_CNT) ? MAX_CNT : n;
    endfunction

    assign counting = state_q inside {W_REQ, W_REL, TURN, R_WAIT, R_ACK};
    assign tmo_hit  = counting && (tmo_q == TMO_LAST);

    always_comb begin
        state_n   = state_q;
        n_cmd_n   = n_cmd_q;
        n_reply_n = n_reply_q;
        wcnt_n    = wcnt_q;
        rcnt_n    = rcnt_q;
        idx_n     = idx_q;
        shift_n   = shift_q;
        reply_n   = reply_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_cmd_n   = clamp_count(n_cmd_words);
                    n_reply_n = clamp_count(n_reply_words);
                    wcnt_n    = '0;
                    rcnt_n    = '0;
                    idx_n     = '0;
                    if (n_cmd_n != '0)        state_n = W_LOAD;
                    else if (n_reply_n != '0) state_n = TURN;
                    else                      state_n = DONE;
                end
            end
            W_LOAD: begin
                if (cmd_valid) begin
                    shift_n = cmd_word;
                    idx_n   = '0;
                    wcnt_n  = wcnt_q + CNT_W'(1);
                    state_n = W_SETUP;
                end
            end
            W_SETUP: state_n = W_REQ;
            W_REQ: begin
                if (ack_s)        state_n = W_REL;
                else if (tmo_hit) state_n = ERROR;
            end
            W_REL: begin
                if (!ack_s) begin
                    if (idx_q != LAST_BYTE) begin
                        idx_n   = idx_q + IDX_W'(1);
                        shift_n = {8'h00, shift_q[31:8]};
                        state_n = W_SETUP;
                    end else if (wcnt_q != n_cmd_q) begin
                        state_n = W_LOAD;
                    end else if (n_reply_q != '0) begin
                        idx_n   = '0;
                        state_n = TURN;
                    end else begin
                        state_n = DONE;
                    end
                end else if (tmo_hit) begin
                    state_n = ERROR;
                end
            end
            TURN: begin
                if (rw_s) begin
                    idx_n   = '0;
                    state_n = R_WAIT;
                end else if (tmo_hit) begin
                    state_n = ERROR;
                end
            end
            R_WAIT: begin
                if (rdy_s) begin
                    reply_n[{idx_q, 3'b000} +: 8] = bus_data_in;
                    state_n = R_ACK;
                end else if (tmo_hit) begin
                    state_n = ERROR;
                end
            end
            R_ACK: begin
                if (!rdy_s) begin
                    if (idx_q != LAST_BYTE) begin
                        idx_n   = idx_q + IDX_W'(1);
                        state_n = R_WAIT;
                    end else begin
                        idx_n   = '0;
                        state_n = R_DELIVER;
                    end
                end else if (tmo_hit) begin
                    state_n = ERROR;
                end
            end
            R_DELIVER: begin
                if (reply_ready) begin
                    rcnt_n  = rcnt_q + CNT_W'(1);
                    state_n = (rcnt_n == n_reply_q) ? DONE : R_WAIT;
                end
            end
            DONE:    state_n = IDLE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The enable spans the whole write phase, including W_LOAD between words.
    assign write_phase_n = (state_n inside {W_SETUP, W_REQ, W_REL}) ||
                           ((state_n == W_LOAD) && (wcnt_n != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            n_cmd_q      <= '0;
            n_reply_q    <= '0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            reply_q      <= '0;
            tmo_q        <= '0;
            cmd_ready    <= 1'b0;
            reply_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            bus_data_out <= 8'h00;
            bus_data_oe  <= 1'b0;
            handshake1_2 <= 1'b0;
            handshake2_1 <= 1'b0;
        end else begin
            state_q      <= state_n;
            n_cmd_q      <= n_cmd_n;
            n_reply_q    <= n_reply_n;
            wcnt_q       <= wcnt_n;
            rcnt_q       <= rcnt_n;
            idx_q        <= idx_n;
            shift_q      <= shift_n;
            reply_q      <= reply_n;
            tmo_q        <= ((state_n != state_q) || !counting) ? '0 : tmo_q + TMO_W'(1);
            cmd_ready    <= (state_n == W_LOAD);
            reply_valid  <= (state_n == R_DELIVER);
            busy         <= (state_n != IDLE);
            done         <= (state_q == DONE) || (state_q == ERROR);
            error        <= (state_q == ERROR);
            bus_data_oe  <= write_phase_n;
            bus_data_out <= (state_n == W_SETUP) ? shift_n[7:0] :
                            (write_phase_n ? bus_data_out : 8'h00);
            handshake1_2 <= (state_n == W_REQ);
            handshake2_1 <= (state_n == R_ACK);
        end
    end

    assign reply_word = reply_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_up_interface_initiator.sv
// Directed bench for up_interface_initiator with a four-phase target model on the bus side.
module tb_up_interface_initiator;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] n_cmd_words, n_reply_words;
    logic [31:0]      cmd_word;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      reply_word;
    logic             reply_valid;
    logic             reply_ready;
    logic             busy, done, error;
    logic [7:0]       bus_data_out;
    logic             bus_data_oe;
    logic [7:0]       bus_data_in;
    logic             RW;
    logic             handshake1_2, handshake1_1, handshake2_2, handshake2_1;
    logic [3:0]       state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic       tgt_ack_en;
    logic [7:0] wr_got_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] exp_q[$];

    up_interface_initiator #(
        .MAX_WORDS(16),
        .TIMEOUT_CYCLES(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .n_cmd_words(n_cmd_words), .n_reply_words(n_reply_words),
        .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .reply_word(reply_word), .reply_valid(reply_valid), .reply_ready(reply_ready),
        .busy(busy), .done(done), .error(error),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in),
        .RW(RW), .handshake1_2(handshake1_2), .handshake1_1(handshake1_1),
        .handshake2_2(handshake2_2), .handshake2_1(handshake2_1),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Write side of the target: acknowledge 3 cycles after the request, release on drop.
    initial begin
        int ack_dly;
        ack_dly = 0;
        handshake1_1 = 1'b0;
        forever begin
            @(negedge clk);
            if (handshake1_1) begin
                if (!handshake1_2) handshake1_1 = 1'b0;
            end else if (handshake1_2 && tgt_ack_en) begin
                ack_dly++;
                if (ack_dly >= 3) begin
                    wr_got_q.push_back(bus_data_out);
                    handshake1_1 = 1'b1;
                    ack_dly = 0;
                end
            end else begin
                ack_dly = 0;
            end
        end
    end

    // Read side of the target: present the next queued byte while RW is high.
    initial begin
        handshake2_2 = 1'b0;
        bus_data_in  = 8'h00;
        forever begin
            @(negedge clk);
            if (!RW) begin
                handshake2_2 = 1'b0;
            end else if (handshake2_2) begin
                if (handshake2_1) handshake2_2 = 1'b0;
            end else if (!handshake2_1 && rd_q.size() > 0) begin
                bus_data_in  = rd_q.pop_front();
                handshake2_2 = 1'b1;
            end
        end
    end

    task automatic start_txn(input int nc, input int nr);
        start = 1'b1;
        n_cmd_words = CNT_W'(nc);
        n_reply_words = CNT_W'(nr);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] w, input int budget, output logic ok);
        ok = 1'b0;
        cmd_word = w;
        cmd_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_reply(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (reply_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output int cycles, output logic err);
        cycles = -1;
        err = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin
                cycles = i;
                err = error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({cmd_ready, reply_valid, busy, done, error, bus_data_oe, handshake1_2, handshake2_1} !== 8'h00)
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {cmd_ready, reply_valid, busy, done, error, bus_data_oe, handshake1_2, handshake2_1});
        else pass_cnt++;
        total_cnt++;
        if (bus_data_out !== 8'h00) $display("FAIL reset_bus_data: got %h required 00", bus_data_out);
        else pass_cnt++;
        total_cnt++;
        if (reply_word !== 32'h0) $display("FAIL reset_reply_word: got %h required 00000000", reply_word);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (state_dbg !== 4'd0 || busy !== 1'b0)
            $display("FAIL reset_idle: state %0d busy %b required state 0 busy 0", state_dbg, busy);
        else pass_cnt++;
    endtask

    task automatic test_write_only();
        logic ok, err;
        int cyc, pulses, oe_seen;
        wr_got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
        tgt_ack_en = 1'b1;
        RW = 1'b0;
        start_txn(1, 0);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL wo_busy: got %b required 1", busy);
        else pass_cnt++;
        send_cmd(32'hDEADBEEF, 20, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL wo_cmd_accept: got %b required 1", ok);
        else pass_cnt++;
        wait_done(500, cyc, err);
        total_cnt++;
        if (cyc < 0) $display("FAIL wo_done: got no done required done within 500 cycles");
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL wo_error: got %b required 0", err);
        else pass_cnt++;
        pulses = 0;
        oe_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
            if (bus_data_oe || handshake1_2) oe_seen++;
        end
        total_cnt++;
        if (pulses != 0 || oe_seen != 0)
            $display("FAIL wo_after: extra done %0d bus active %0d required 0 and 0", pulses, oe_seen);
        else pass_cnt++;
        total_cnt++;
        if (wr_got_q.size() != 4) $display("FAIL wo_byte_count: got %0d required 4", wr_got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (wr_got_q[i] !== exp_q[i])
                $display("FAIL wo_byte%0d: got %h required %h", i, wr_got_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        logic ok, err;
        int cyc, drops;
        wr_got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        rd_q.delete();
        rd_q.push_back(8'h44); rd_q.push_back(8'h33); rd_q.push_back(8'h22); rd_q.push_back(8'h11);
        RW = 1'b1;
        start_txn(2, 1);
        send_cmd(32'h00000001, 20, ok);
        send_cmd(32'h12345678, 100, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL wr_cmd2_accept: got %b required 1", ok);
        else pass_cnt++;
        wait_reply(800, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL wr_reply_valid: got no reply_valid required within 800 cycles");
        else pass_cnt++;
        total_cnt++;
        if (reply_word !== 32'h11223344) $display("FAIL wr_reply_word: got %h required 11223344", reply_word);
        else pass_cnt++;
        drops = 0;
        repeat (5) begin
            @(negedge clk);
            if (!reply_valid) drops++;
        end
        total_cnt++;
        if (drops != 0) $display("FAIL wr_valid_hold: got %0d drops required 0", drops);
        else pass_cnt++;
        reply_ready = 1'b1;
        @(negedge clk);
        reply_ready = 1'b0;
        wait_done(10, cyc, err);
        total_cnt++;
        if (cyc != 1 || err !== 1'b0)
            $display("FAIL wr_done: got cycles %0d error %b required 1 and 0", cyc, err);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (wr_got_q[i] !== exp_q[i])
                $display("FAIL wr_byte%0d: got %h required %h", i, wr_got_q[i], exp_q[i]);
            else pass_cnt++;
        end
        RW = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic ok, err;
        int cyc, bad;
        rd_q.delete();
        rd_q.push_back(8'hAA); rd_q.push_back(8'hBB); rd_q.push_back(8'hCC); rd_q.push_back(8'hDD);
        RW = 1'b1;
        reply_ready = 1'b0;
        start_txn(0, 1);
        wait_reply(400, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL bp_reply_valid: got no reply_valid required within 400 cycles");
        else pass_cnt++;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!reply_valid || reply_word !== 32'hDDCCBBAA || done || error) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL bp_stall: got %0d bad cycles required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (reply_word !== 32'hDDCCBBAA) $display("FAIL bp_reply_word: got %h required ddccbbaa", reply_word);
        else pass_cnt++;
        reply_ready = 1'b1;
        @(negedge clk);
        reply_ready = 1'b0;
        wait_done(10, cyc, err);
        total_cnt++;
        if (cyc != 1 || err !== 1'b0)
            $display("FAIL bp_done: got cycles %0d error %b required 1 and 0", cyc, err);
        else pass_cnt++;
        RW = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic ok, err;
        int cyc;
        wr_got_q.delete();
        tgt_ack_en = 1'b0;
        RW = 1'b0;
        start_txn(1, 0);
        send_cmd(32'hA5A5A5A5, 20, ok);
        for (int i = 0; i < 20; i++) begin
            if (handshake1_2) break;
            @(negedge clk);
        end
        total_cnt++;
        if (handshake1_2 !== 1'b1) $display("FAIL to_req: got %b required 1", handshake1_2);
        else pass_cnt++;
        wait_done(40, cyc, err);
        total_cnt++;
        if (cyc < 16 || cyc > 20) $display("FAIL to_latency: got %0d cycles required 16..20", cyc);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL to_error: got %b required 1", err);
        else pass_cnt++;
        total_cnt++;
        if ({handshake1_2, handshake2_1, bus_data_oe, bus_data_out} !== 11'h000)
            $display("FAIL to_bus_idle: got %h required 000",
                     {handshake1_2, handshake2_1, bus_data_oe, bus_data_out});
        else pass_cnt++;
        total_cnt++;
        if (wr_got_q.size() != 0) $display("FAIL to_no_bytes: got %0d required 0", wr_got_q.size());
        else pass_cnt++;
        tgt_ack_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero_counts();
        int cyc, act, pulses;
        logic b1, b2;
        cyc = -1;
        act = 0;
        pulses = 0;
        b1 = 1'b0;
        b2 = 1'b0;
        start = 1'b1;
        n_cmd_words = '0;
        n_reply_words = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 1) b1 = busy;
            if (i == 2) b2 = busy;
            if (bus_data_oe || handshake1_2 || handshake2_1 || cmd_ready || reply_valid) act++;
            if (done) begin
                pulses++;
                if (cyc < 0) cyc = i;
            end
        end
        total_cnt++;
        if (cyc != 2) $display("FAIL zero_done_latency: got %0d required 2", cyc);
        else pass_cnt++;
        total_cnt++;
        if (pulses != 1) $display("FAIL zero_done_pulses: got %0d required 1", pulses);
        else pass_cnt++;
        total_cnt++;
        if (act != 0) $display("FAIL zero_bus_quiet: got %0d active cycles required 0", act);
        else pass_cnt++;
        total_cnt++;
        if (b1 !== 1'b1 || b2 !== 1'b0) $display("FAIL zero_busy: got %b%b required 10", b1, b2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        logic ok, err;
        int cyc, pulses;
        rd_q.delete();
        rd_q.push_back(8'h5A); rd_q.push_back(8'h6B); rd_q.push_back(8'h7C); rd_q.push_back(8'h8D);
        RW = 1'b1;
        start_txn(0, 1);
        for (int i = 0; i < 100; i++) begin
            if (handshake2_1) break;
            @(negedge clk);
        end
        total_cnt++;
        if (handshake2_1 !== 1'b1) $display("FAIL rst_reach_rack: got %b required 1", handshake2_1);
        else pass_cnt++;
        reset = 1'b1;
        RW = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({handshake2_1, busy, done} !== 3'b000)
            $display("FAIL rst_abort: got hs2_1/busy/done %b required 000", {handshake2_1, busy, done});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        rd_q.delete();
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || error) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL rst_no_done: got %0d pulses required 0", pulses);
        else pass_cnt++;
        wr_got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h0D); exp_q.push_back(8'hF0); exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
        rd_q.push_back(8'h01); rd_q.push_back(8'h02); rd_q.push_back(8'h03); rd_q.push_back(8'h04);
        RW = 1'b1;
        start_txn(1, 1);
        send_cmd(32'hCAFEF00D, 20, ok);
        wait_reply(800, ok);
        total_cnt++;
        if (ok !== 1'b1 || reply_word !== 32'h04030201)
            $display("FAIL rst_fresh_reply: got valid %b word %h required 1 04030201", ok, reply_word);
        else pass_cnt++;
        reply_ready = 1'b1;
        @(negedge clk);
        reply_ready = 1'b0;
        wait_done(10, cyc, err);
        total_cnt++;
        if (cyc != 1 || err !== 1'b0)
            $display("FAIL rst_fresh_done: got cycles %0d error %b required 1 and 0", cyc, err);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (wr_got_q[i] !== exp_q[i])
                $display("FAIL rst_fresh_byte%0d: got %h required %h", i, wr_got_q[i], exp_q[i]);
            else pass_cnt++;
        end
        RW = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        n_cmd_words = '0;
        n_reply_words = '0;
        cmd_word = '0;
        cmd_valid = 1'b0;
        reply_ready = 1'b0;
        RW = 1'b0;
        tgt_ack_en = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_only();
        test_write_read();
        test_backpressure();
        test_timeout();
        test_zero_counts();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
